// File: rtl/kmeans_pkg.sv
// Width helpers shared by the k-d tree clustering datapath (manhattan_distance, cluster_CE).
package kmeans_pkg;

    function automatic int dim_w(input int max_val);
        return $clog2(max_val);
    endfunction

    function automatic int dist_w(input int n_coord, input int max_val);
        return $clog2(n_coord * max_val + 1);
    endfunction

    // A single-coordinate vector still needs a 1-bit axis port.
    function automatic int axis_w(input int n_coord);
        return (n_coord > 1) ? $clog2(n_coord) : 1;
    endfunction

endpackage

// File: rtl/abs_diff.sv
// Unsigned |a - b| computed as max - min, so the result never wraps.
module abs_diff #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/manhattan_distance.sv
// Two-stage registered L1 distance between point and center, plus the split-axis difference.
module manhattan_distance
    import kmeans_pkg::*;
#(
    parameter int dim        = 3,
    parameter int data_range = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [axis_w(dim)-1:0]            axis,
    input  logic [dim*dim_w(data_range)-1:0]  point,
    input  logic [dim*dim_w(data_range)-1:0]  center,
    output logic [dist_w(dim, data_range)-1:0] dst,
    output logic [dim_w(data_range)-1:0]      axis_dst,
    output logic                              dst_done
);

    localparam int DIM_W  = dim_w(data_range);
    localparam int DIST_W = dist_w(dim, data_range);
    localparam int AXIS_W = axis_w(dim);
    localparam int TAG_W  = AXIS_W + 2 * dim * DIM_W;

    logic [DIM_W-1:0]  diff     [dim];
    logic [DIM_W-1:0]  diff_r   [dim];
    logic [DIM_W-1:0]  axis_sel;
    logic [DIM_W-1:0]  axis_diff_r;
    logic [TAG_W-1:0]  sample;
    logic [TAG_W-1:0]  s1_tag;
    logic              v1;
    logic [DIST_W-1:0] psum     [dim+1];

    for (genvar i = 0; i < dim; i++) begin : g_diff
        abs_diff #(.W(DIM_W)) u_abs_diff (
            .a(point[i*DIM_W +: DIM_W]),
            .b(center[i*DIM_W +: DIM_W]),
            .y(diff[i])
        );
    end

    // An axis index at or beyond dim matches no coordinate and selects zero.
    always_comb begin
        axis_sel = '0;
        for (int i = 0; i < dim; i++) begin
            if (axis == AXIS_W'(i)) axis_sel = diff[i];
        end
    end

    assign sample = {axis, point, center};

    // NOTE: every register here uses <= so all stages update from pre-edge values;
    // blocking = would let stage 2 see this edge's stage-1 result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < dim; i++) diff_r[i] <= '0;
            axis_diff_r <= '0;
            s1_tag      <= '0;
            v1          <= 1'b0;
        end else begin
            for (int i = 0; i < dim; i++) diff_r[i] <= diff[i];
            axis_diff_r <= axis_sel;
            s1_tag      <= sample;
            v1          <= 1'b1;
        end
    end

    assign psum[0] = '0;
    for (genvar i = 0; i < dim; i++) begin : g_sum
        assign psum[i+1] = psum[i] + DIST_W'(diff_r[i]);
    end

    // dst_done asserts only when the stage-1 tag still matches what is on the inputs now.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst      <= '0;
            axis_dst <= '0;
            dst_done <= 1'b0;
        end else begin
            dst      <= psum[dim];
            axis_dst <= axis_diff_r;
            dst_done <= v1 && (s1_tag == sample);
        end
    end

endmodule

// File: tb/tb_manhattan_distance.sv
// Directed and random-stream bench for manhattan_distance against an arithmetic reference model.
module tb_manhattan_distance;

    localparam int DIM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  axis;
    logic [23:0] point;
    logic [23:0] center;
    logic [9:0]  dst;
    logic [7:0]  axis_dst;
    logic        dst_done;

    int n_checks = 0;
    int n_fail   = 0;

    manhattan_distance dut (
        .clk(clk), .rst(rst), .axis(axis), .point(point), .center(center),
        .dst(dst), .axis_dst(axis_dst), .dst_done(dst_done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pack(input int c0, input int c1, input int c2);
        logic [23:0] v;
        v[7:0]   = 8'(c0);
        v[15:8]  = 8'(c1);
        v[23:16] = 8'(c2);
        return v;
    endfunction

    function automatic int coord(input logic [23:0] v, input int i);
        return int'(v[i*8 +: 8]);
    endfunction

    function automatic int model_dst(input logic [23:0] p, input logic [23:0] c);
        int s = 0;
        for (int i = 0; i < DIM; i++) begin
            int d = coord(p, i) - coord(c, i);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    function automatic int model_axis(input int ax, input logic [23:0] p, input logic [23:0] c);
        int d;
        if (ax >= DIM) return 0;
        d = coord(p, ax) - coord(c, ax);
        return (d < 0) ? -d : d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int e_dst, input int e_axis, input logic e_done);
        n_checks++;
        assert (dst === 10'(e_dst)) else begin
            n_fail++;
            $error("FAIL %s dst: observed %0d expected %0d", tag, dst, e_dst);
        end
        n_checks++;
        assert (axis_dst === 8'(e_axis)) else begin
            n_fail++;
            $error("FAIL %s axis_dst: observed %0d expected %0d", tag, axis_dst, e_axis);
        end
        n_checks++;
        assert (dst_done === e_done) else begin
            n_fail++;
            $error("FAIL %s dst_done: observed %0b expected %0b", tag, dst_done, e_done);
        end
    endtask

    initial begin
        logic [1:0]  prev_axis;
        logic [23:0] prev_point, prev_center;
        logic [1:0]  n_axis;
        logic [23:0] n_point, n_center;

        // Reset with the basic vectors already applied.
        rst    = 1'b1;
        axis   = 2'd1;
        point  = pack(10, 20, 30);
        center = pack(13, 15, 30);
        step();
        step();
        check("reset", 0, 0, 1'b0);

        rst = 1'b0;
        step();
        check("first_edge_after_release", 0, 0, 1'b0);
        step();
        check("basic", 8, 5, 1'b1);
        step();
        check("basic_hold", 8, 5, 1'b1);

        center = pack(10, 20, 30);
        step();
        check("change_center", 8, 5, 1'b0);
        step();
        check("change_settled", 0, 0, 1'b1);

        axis   = 2'd2;
        point  = pack(255, 255, 255);
        center = pack(0, 0, 0);
        step();
        step();
        check("extremes", 765, 255, 1'b1);

        point  = pack(0, 0, 0);
        center = pack(255, 255, 255);
        step();
        check("swap_transition", 765, 255, 1'b0);
        step();
        check("extremes_swapped", 765, 255, 1'b1);

        axis   = 2'd3;
        point  = pack(1, 2, 3);
        center = pack(4, 4, 4);
        step();
        step();
        check("axis_out_of_range", 6, 0, 1'b1);

        rst = 1'b1;
        step();
        check("mid_reset", 0, 0, 1'b0);
        rst = 1'b0;
        step();
        check("post_reset_edge1", 0, 0, 1'b0);
        step();
        check("post_reset_edge2", 6, 0, 1'b1);

        // Random stream: new inputs every edge, outputs lag by one observed step.
        prev_axis   = axis;
        prev_point  = point;
        prev_center = center;
        for (int n = 0; n < 200; n++) begin
            n_axis   = 2'($urandom_range(0, 3));
            n_point  = 24'($urandom());
            n_center = 24'($urandom());
            if (n_axis == axis && n_point == point && n_center == center)
                n_point[0] = ~n_point[0];
            axis   = n_axis;
            point  = n_point;
            center = n_center;
            step();
            check($sformatf("stream_%0d", n),
                  model_dst(prev_point, prev_center),
                  model_axis(int'(prev_axis), prev_point, prev_center),
                  1'b0);
            prev_axis   = n_axis;
            prev_point  = n_point;
            prev_center = n_center;
        end

        // Hold the last random vector and expect it to settle.
        step();
        check("stream_settle",
              model_dst(prev_point, prev_center),
              model_axis(int'(prev_axis), prev_point, prev_center),
              1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/manhattan_distance.md
# manhattan_distance

Registered L1 (Manhattan) distance unit between a point and a cluster center, with the per-axis absolute difference for the current k-d tree split axis. It sits inside each `cluster_CE` of the k-d tree clustering datapath. Inputs are sampled every clock with no start strobe. `dst_done` tells the owner when the outputs correspond to the inputs currently being presented.

## Interface
- `dim`, default 3: number of coordinates per vector.
- `data_range`, default 255: maximum coordinate value.
- Derived `DIM_W` = $clog2(data_range), 8 by default: coordinate width. `data_range` must be less than 2^DIM_W.
- Derived `DIST_W` = $clog2(dim*data_range+1), 10 by default.
- Derived `AXIS_W` = $clog2(dim), 2 by default.
- Ports are positional, in this order:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `axis`  in  AXIS_W: split axis index.
- `point`  in  dim*DIM_W: point vector. Coordinate i is at bits [i*DIM_W +: DIM_W]; coordinate 0 is in the LSBs.
- `center`  in  dim*DIM_W: center vector, packed the same way as `point`.
- `dst`  out  DIST_W: sum over i of |point_i − center_i|.
- `axis_dst`  out  DIM_W: |point_axis − center_axis|.
- `dst_done`  out  1: outputs are valid for the most recently sampled inputs.

## Operation
- All coordinates are unsigned. Each absolute difference is computed as max−min, so it never wraps.
- The sum is computed at DIST_W width and cannot overflow for any legal inputs.
- If `axis` ≥ `dim`, `axis_dst` = 0. `dst` is unaffected.
- Sampled tuple S = {axis, point, center}.
- Stage 1 registers:
  - the `dim` absolute differences,
  - the selected axis difference,
  - a copy of S (`s1_tag`),
  - a valid bit `v1`.
- Stage 2 registers the outputs:
  - `dst` = sum of the stage-1 differences,
  - `axis_dst` = the stage-1 axis difference.
- `dst_done` is registered as `v1` AND (`s1_tag` == S sampled at the same edge). It means the outputs now loaded were computed from the values still on the inputs.
- No enable input; the pipeline advances every cycle.

## Timing
- Reset: while `rst` is high at an edge, all registers clear. `dst`=0, `axis_dst`=0, `dst_done`=0, `v1`=0. This also applies to a reset asserted mid-computation; in-flight results are discarded.
- Latency is 2 edges. Inputs sampled at edge n appear on `dst`/`axis_dst` after edge n+1.
- Inputs held constant from edge k onward (k being the first edge with `rst` low): outputs correct and `dst_done`=1 after edge k+1. `dst_done` stays 1 while the inputs stay unchanged.
- Any change of `axis`, `point` or `center` sampled at edge m: `dst_done`=0 after edge m. `dst_done` returns to 1 after edge m+1 if the inputs are held.
- Inputs changing every cycle: `dst_done` stays 0. Outputs still track their inputs with 2-edge latency.
- The first edge after reset release: `dst_done`=0, because `v1` was 0.

## Structure
- Shared package `kmeans_pkg` holds the width helper constants (DIM_W, DIST_W, AXIS_W as functions of dim and data_range). These are shared with `cluster_CE`.
- One natural sub-module: `abs_diff` (unsigned |a−b|, width DIM_W), instantiated `dim` times.
- The axis select reuses the `abs_diff` outputs through a mux.
- The adder tree is a generate loop in the top module.

## Test plan
- Basic: point=(10,20,30), center=(13,15,30), axis=1, held from reset release -> after 2 edges `dst`=8, `axis_dst`=5, `dst_done`=1.
- Extremes: point=(255,255,255), center=(0,0,0), axis=2 -> `dst`=765 (no overflow), `axis_dst`=255. Swapped operands -> same values.
- Input change: from the basic case, change center to (10,20,30) for one edge and hold -> `dst_done`=0 for one cycle, then `dst`=0, `axis_dst`=0, `dst_done`=1.
- Axis out of range: axis=3 with point=(1,2,3), center=(4,4,4) -> `dst`=6, `axis_dst`=0, `dst_done`=1.
- Reset mid-operation: assert `rst` for one edge while valid -> all outputs 0 and `dst_done`=0 next cycle. After release with inputs held, valid again after 2 edges.
- Streaming: new random vectors every cycle, compared against a software model delayed by 2 cycles -> `dst`/`axis_dst` match every cycle, and `dst_done` is always 0.
